// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline control types for the hazard controller
package cpu_pkg;

   localparam int REG_ADDR_W  = 5;
   localparam int STALL_CNT_W = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } stage_en_t;

   typedef struct packed {
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } stage_flush_t;

   function automatic logic src_hit(input logic                  uses,
                                    input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] rd);
      return uses && (src == rd);
   endfunction

endpackage

// File: rtl/load_use_detector.sv
// rtl/load_use_detector.sv - flags an ID-stage read of a load still in EX
module load_use_detector
   import cpu_pkg::*;
(
   input  logic                  ex_mem_read_en,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   output logic                  hazard
);

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign hazard = ex_mem_read_en && (ex_rd_addr != '0) &&
                   (src_hit(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                    src_hit(id_uses_rs2, id_rs2_addr, ex_rd_addr));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stage enable/flush control for memory, divide, branch and load-use hazards
module pipeline_hazard_controller
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
   input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
   input  logic                   id_uses_rs1,
   input  logic                   id_uses_rs2,
   input  logic [REG_ADDR_W-1:0]  ex_rd_addr,
   input  logic                   ex_mem_read_en,
   input  logic                   ex_div_start,
   input  logic                   div_done,
   input  logic                   branch_taken,
   input  logic                   dmem_req,
   input  logic                   dmem_ready,
   input  logic                   perf_clear,
   output logic                   pc_enable,
   output logic                   if_id_enable,
   output logic                   id_ex_enable,
   output logic                   ex_mem_enable,
   output logic                   mem_wb_enable,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   ex_mem_flush,
   output logic                   mem_wb_flush,
   output logic [1:0]             state,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic                   mem_timeout_err
);

   localparam logic [16:0] TIMEOUT_LIM = 17'(MEM_TIMEOUT);

   hz_state_t               state_q;
   hz_state_t               state_d;
   logic                    saved_div_q;
   logic [15:0]             dwell_q;
   logic [16:0]             dwell_inc;
   logic [STALL_CNT_W-1:0]  stall_q;
   logic                    err_q;
   logic                    mem_stall;
   logic                    mem_enter;
   logic                    resume_div;
   logic                    load_use;
   stage_en_t               en;
   stage_flush_t            fl;

   load_use_detector u_load_use (
      .ex_mem_read_en (ex_mem_read_en),
      .ex_rd_addr     (ex_rd_addr),
      .id_rs1_addr    (id_rs1_addr),
      .id_rs2_addr    (id_rs2_addr),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .hazard         (load_use)
   );

   assign mem_stall = dmem_req && !dmem_ready;
   assign mem_enter = mem_stall && (state_q != MEM_WAIT);
   // The release cycle of a memory wait behaves like the state it interrupted
   assign resume_div = (state_q == DIV_WAIT) || ((state_q == MEM_WAIT) && saved_div_q);

   always_comb begin
      en      = '1;
      fl      = '0;
      state_d = state_q;
      if (mem_stall) begin
         en        = '0;
         fl.mem_wb = 1'b1;
         state_d   = MEM_WAIT;
      end else if (resume_div) begin
         if (!div_done) begin
            en.pc     = 1'b0;
            en.if_id  = 1'b0;
            en.id_ex  = 1'b0;
            fl.ex_mem = 1'b1;
         end
         state_d = div_done ? RUN : DIV_WAIT;
      end else begin
         if ((state_q == RUN) && branch_taken) begin
            fl.if_id = 1'b1;
            fl.id_ex = 1'b1;
         end else if (load_use) begin
            en.pc    = 1'b0;
            en.if_id = 1'b0;
            fl.id_ex = 1'b1;
         end
         // A divide finishing in its start cycle never needs to wait
         state_d = (ex_div_start && !div_done) ? DIV_WAIT : RUN;
      end
      if (!(state_q inside {RUN, DIV_WAIT, MEM_WAIT})) begin
         state_d = RUN;
      end
      if (rst) begin
         en = '0;
         fl = '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         saved_div_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (mem_enter) begin
            saved_div_q <= (state_q == DIV_WAIT);
         end
      end
   end

   assign dwell_inc = {1'b0, dwell_q} + 17'd1;

   // Error is sticky; the FSM keeps waiting regardless
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_q <= '0;
         err_q   <= 1'b0;
      end else if (mem_enter) begin
         dwell_q <= '0;
      end else if ((state_q == MEM_WAIT) && mem_stall) begin
         if (dwell_q != 16'hFFFF) begin
            dwell_q <= dwell_inc[15:0];
         end
         if (dwell_inc >= TIMEOUT_LIM) begin
            err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (perf_clear) begin
         stall_q <= '0;
      end else if (!en.pc && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign pc_enable       = en.pc;
   assign if_id_enable    = en.if_id;
   assign id_ex_enable    = en.id_ex;
   assign ex_mem_enable   = en.ex_mem;
   assign mem_wb_enable   = en.mem_wb;
   assign if_id_flush     = fl.if_id;
   assign id_ex_flush     = fl.id_ex;
   assign ex_mem_flush    = fl.ex_mem;
   assign mem_wb_flush    = fl.mem_wb;
   assign state           = state_q;
   assign stall_cycles    = stall_q;
   assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  ex_rd_addr;
   logic        ex_mem_read_en;
   logic        ex_div_start;
   logic        div_done;
   logic        branch_taken;
   logic        dmem_req;
   logic        dmem_ready;
   logic        perf_clear;
   logic        pc_enable;
   logic        if_id_enable;
   logic        id_ex_enable;
   logic        ex_mem_enable;
   logic        mem_wb_enable;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        ex_mem_flush;
   logic        mem_wb_flush;
   logic [1:0]  state;
   logic [15:0] stall_cycles;
   logic        mem_timeout_err;

   logic [4:0]  en_v;
   logic [3:0]  fl_v;
   int          checks;
   int          errors;

   assign en_v = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable};
   assign fl_v = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd_addr      (ex_rd_addr),
      .ex_mem_read_en  (ex_mem_read_en),
      .ex_div_start    (ex_div_start),
      .div_done        (div_done),
      .branch_taken    (branch_taken),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .perf_clear      (perf_clear),
      .pc_enable       (pc_enable),
      .if_id_enable    (if_id_enable),
      .id_ex_enable    (id_ex_enable),
      .ex_mem_enable   (ex_mem_enable),
      .mem_wb_enable   (mem_wb_enable),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_flush    (ex_mem_flush),
      .mem_wb_flush    (mem_wb_flush),
      .state           (state),
      .stall_cycles    (stall_cycles),
      .mem_timeout_err (mem_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0; errors = 0;
      clk = 1'b0; rst = 1'b1;
      id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd_addr = '0; ex_mem_read_en = 1'b0; ex_div_start = 1'b0; div_done = 1'b0;
      branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; perf_clear = 1'b0;
      #12;
      check_eq("rst_en", 32'(en_v), 32'h00);
      check_eq("rst_fl", 32'(fl_v), 32'hF);
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_stall", 32'(stall_cycles), 32'd0);
      check_eq("rst_err", 32'(mem_timeout_err), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      check_eq("idle_en", 32'(en_v), 32'h1F);
      check_eq("idle_fl", 32'(fl_v), 32'h0);

      // load-use through rs2
      ex_mem_read_en = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1; #1;
      check_eq("lu2_en", 32'(en_v), 32'b00111);
      check_eq("lu2_fl", 32'(fl_v), 32'b0100);
      tick();
      ex_rd_addr = 5'd0; #1;
      check_eq("lu_x0_en", 32'(en_v), 32'h1F);
      check_eq("lu_x0_fl", 32'(fl_v), 32'h0);
      check_eq("lu_stall", 32'(stall_cycles), 32'd1);
      tick();
      ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0; #1;
      check_eq("lu1_en", 32'(en_v), 32'b00111);
      tick();
      branch_taken = 1'b1; #1;
      check_eq("brlu_en", 32'(en_v), 32'h1F);
      check_eq("brlu_fl", 32'(fl_v), 32'b1100);
      check_eq("brlu_stall_pre", 32'(stall_cycles), 32'd2);
      tick();
      branch_taken = 1'b0; ex_mem_read_en = 1'b0; id_uses_rs1 = 1'b0; #1;
      check_eq("brlu_stall_post", 32'(stall_cycles), 32'd2);

      // multi-cycle divide, branch ignored while waiting
      ex_div_start = 1'b1; #1;
      check_eq("div_start_en", 32'(en_v), 32'h1F);
      tick();
      ex_div_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         branch_taken = (i == 1); #1;
         check_eq("div_state", 32'(state), 32'd1);
         check_eq("div_en", 32'(en_v), 32'b00011);
         check_eq("div_fl", 32'(fl_v), 32'b0010);
         tick();
      end
      branch_taken = 1'b0; div_done = 1'b1; #1;
      check_eq("div_done_en", 32'(en_v), 32'h1F);
      check_eq("div_done_fl", 32'(fl_v), 32'h0);
      check_eq("div_stall", 32'(stall_cycles), 32'd6);
      tick();
      div_done = 1'b0; #1;
      check_eq("div_exit_state", 32'(state), 32'd0);

      perf_clear = 1'b1; #1;
      tick();
      perf_clear = 1'b0; #1;
      check_eq("perf_clear", 32'(stall_cycles), 32'd0);

      ex_div_start = 1'b1; div_done = 1'b1; #1;
      tick();
      ex_div_start = 1'b0; div_done = 1'b0; #1;
      check_eq("div_single_state", 32'(state), 32'd0);

      // memory stall inside a divide
      ex_div_start = 1'b1; #1;
      tick();
      ex_div_start = 1'b0; dmem_req = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("mdiv_state", 32'(state), (i == 0) ? 32'd1 : 32'd2);
         check_eq("mdiv_en", 32'(en_v), 32'h00);
         check_eq("mdiv_fl", 32'(fl_v), 32'b0001);
         tick(); #1;
      end
      dmem_ready = 1'b1; #1;
      check_eq("mdiv_rel_state", 32'(state), 32'd2);
      check_eq("mdiv_rel_en", 32'(en_v), 32'b00011);
      check_eq("mdiv_rel_fl", 32'(fl_v), 32'b0010);
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0; div_done = 1'b1; #1;
      check_eq("mdiv_back_state", 32'(state), 32'd1);
      check_eq("mdiv_stall", 32'(stall_cycles), 32'd4);
      check_eq("mdiv_err", 32'(mem_timeout_err), 32'd0);
      tick();
      div_done = 1'b0; #1;
      check_eq("mdiv_run_state", 32'(state), 32'd0);

      // memory timeout
      dmem_req = 1'b1; #1;
      check_eq("mto_entry_en", 32'(en_v), 32'h00);
      tick();
      for (int i = 1; i <= 5; i++) begin
         tick(); #1;
         check_eq("mto_err", 32'(mem_timeout_err), 32'(i >= 4));
         check_eq("mto_state", 32'(state), 32'd2);
      end
      dmem_ready = 1'b1; #1;
      check_eq("mto_rel_en", 32'(en_v), 32'h1F);
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0; #1;
      check_eq("mto_exit_state", 32'(state), 32'd0);
      check_eq("mto_sticky", 32'(mem_timeout_err), 32'd1);

      // asynchronous reset mid-divide
      ex_div_start = 1'b1; #1;
      tick();
      ex_div_start = 1'b0; #2;
      rst = 1'b1; #1;
      check_eq("arst_state", 32'(state), 32'd0);
      check_eq("arst_fl", 32'(fl_v), 32'hF);
      check_eq("arst_en", 32'(en_v), 32'h00);
      check_eq("arst_err", 32'(mem_timeout_err), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      check_eq("post_rst_en", 32'(en_v), 32'h1F);

      // stall counter saturation
      ex_div_start = 1'b1; #1;
      tick();
      ex_div_start = 1'b0;
      for (int i = 0; i < 65540; i++) tick();
      #1;
      check_eq("sat_stall", 32'(stall_cycles), 32'hFFFF);
      perf_clear = 1'b1; #1;
      tick();
      perf_clear = 1'b0; #1;
      check_eq("clr_over_inc", 32'(stall_cycles), 32'd0);
      div_done = 1'b1; #1;
      tick();
      div_done = 1'b0; #1;
      check_eq("final_state", 32'(state), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
